adc_frame_buffer: RTL and testbench
===================================

Name: adc_frame_buffer

Overview:
Sits directly downstream of the SPI ADC receiver and upstream of the FFT stage. Issues periodic one-cycle `sample` requests to the ADC receiver and captures each returned word on its data-valid. Packs the words into frames of 2^N_LOG2 samples in a ping-pong (two-bank) buffer. Hands complete frames to the FFT through a ready/ack handshake and a registered random-access read port.

Parameters:
MSB, 8, sample width in bits; matches ADC receiver DATA_OUT width
N_LOG2, 5, log2 of frame length (default 32 samples per frame)
SAMPLE_DIV, 1024, clk cycles between sample requests; must be >= 2 and must exceed ADC conversion time

Ports:
clk  input  1  system clock; all logic on posedge
rst  input  1  synchronous, active-high reset
enable  input  1  1 = run sample trigger; 0 = hold trigger
sample  output  1  one-cycle request pulse to ADC receiver `sample` input
adc_data  input  MSB  ADC receiver DATA_OUT
adc_dv  input  1  ADC receiver DV; may stay high for more than 1 cycle
frame_ready  output  1  a complete frame is available in the read bank
frame_ack  input  1  one-cycle pulse from consumer; releases the read bank
rd_addr  input  N_LOG2  read index into the read bank
rd_data  output  MSB  registered read data
overrun  output  1  sticky: a frame was discarded because the read bank was still held
trig_miss  output  1  sticky: a trigger was suppressed because a conversion was still pending

Behaviour:
- Reset (rst=1 at posedge):
  - sample, frame_ready, rd_data, overrun and trig_miss all go to 0.
  - Divider, write index, busy and dv_prev go to 0.
  - wr_bank=0, rd_bank=1.
  - Memory contents are not reset.
- Trigger divider:
  - While enable=1, div counts 0..SAMPLE_DIV-1 and wraps.
  - At div==SAMPLE_DIV-1: if busy=0, sample=1 for exactly that one cycle and busy is set. If busy=1, no pulse and trig_miss is set.
  - While enable=0, div is held at 0 and no pulses are issued. A pending conversion is still captured.
- Capture:
  - dv_prev registers adc_dv.
  - A capture event is adc_dv=1 && dv_prev=0 && busy=1. On that cycle adc_data is latched and busy is cleared.
  - A DV rising edge with busy=0 (e.g. a conversion started before reset) is ignored.
- Write:
  - The cycle after capture, mem[wr_bank][waddr(wr_idx)] <= latched data, and wr_idx increments modulo 2^N_LOG2.
  - waddr = wr_idx (see Optional Feature).
- Frame completion, when the write with wr_idx == 2^N_LOG2-1 occurs:
  - If frame_ready=0 (after this cycle's ack is applied): swap banks, so rd_bank <= wr_bank and wr_bank <= ~wr_bank. frame_ready=1 from the next cycle.
  - Else: no swap; the bank is overwritten by the next frame and overrun is set.
- Handshake:
  - frame_ack while frame_ready=1 clears frame_ready next cycle.
  - frame_ack while frame_ready=0 is ignored.
  - Ack and completion in the same cycle: ack is applied first, then the swap. frame_ready stays 1 with the new rd_bank, and overrun is not set.
- Read port:
  - rd_data <= mem[rd_bank][rd_addr] every cycle, 1-cycle latency, independent of frame_ready.
  - Contents are only meaningful while frame_ready=1.
  - rd_bank never changes while frame_ready=1.
- overrun and trig_miss clear only on rst.

Optional Feature:
Macro ADC_FRAME_BITREV_EN.
- Defined: waddr = bit-reverse of wr_idx over N_LOG2 bits. The FFT reads rd_addr 0..N-1 and gets samples in bit-reversed input order for decimation-in-time.
- Undefined: waddr = wr_idx (natural order). No other behaviour differs.

Test Plan:
Bench settings: N_LOG2=3, SAMPLE_DIV=16, and an ADC model that raises DV for 2 cycles, 10 cycles after each `sample`.
1. Reset then enable=1 -> first sample pulse at cycle 15 after enable; pulses every 16 cycles, each exactly 1 cycle wide; trig_miss=0.
2. ADC returns 8'h10..8'h17 for 8 conversions -> frame_ready rises 2 cycles after the 8th DV edge; reading rd_addr 0..7 returns 10..17 natural, or 10,14,12,16,11,15,13,17 with ADC_FRAME_BITREV_EN; 2-cycle DV captured once per conversion.
3. No ack across 16 more conversions -> overrun=1 after 16th; frame_ready stays 1; read bank data still 10..17.
4. frame_ack on the same cycle as the next frame completion -> frame_ready stays 1, rd_bank toggles, overrun unchanged.
5. ADC model delays DV to 20 cycles -> every second trigger suppressed, trig_miss=1, no sample pulse while busy.
6. rst asserted mid-conversion, DV arrives 5 cycles after rst release -> edge ignored, wr_idx=0, all outputs 0.

Source files
------------

// File: rtl/adc_frame_buffer.sv
// adc_frame_buffer: triggers ADC conversions and packs samples into ping-pong frames for the FFT.
// Define ADC_FRAME_BITREV_EN to store each frame in bit-reversed index order.
module adc_frame_buffer #(
  parameter int MSB        = 8,
  parameter int N_LOG2     = 5,
  parameter int SAMPLE_DIV = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  output logic              sample,
  input  logic [MSB-1:0]    adc_data,
  input  logic              adc_dv,
  output logic              frame_ready,
  input  logic              frame_ack,
  input  logic [N_LOG2-1:0] rd_addr,
  output logic [MSB-1:0]    rd_data,
  output logic              overrun,
  output logic              trig_miss
);
  localparam int DW = (SAMPLE_DIV > 2) ? $clog2(SAMPLE_DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(SAMPLE_DIV - 1);
  localparam logic [N_LOG2-1:0] IDX_LAST = '1;
  logic [DW-1:0]     r_div;
  logic              r_busy, r_dv_prev, r_wr_en, r_wr_bank, r_rd_bank;
  logic              r_frame_ready, r_overrun, r_trig_miss;
  logic [MSB-1:0]    r_cap_data, r_rd_data;
  logic [N_LOG2-1:0] r_wr_idx, w_waddr;
  logic [MSB-1:0]    r_mem [2**(N_LOG2+1)];
  logic              w_tick, w_fire, w_cap, w_last, w_held;
  assign w_tick = enable && r_div == DIV_LAST;
  assign w_fire = w_tick && !r_busy;
  // Only a DV rising edge that answers our own outstanding request is captured.
  assign w_cap  = adc_dv && !r_dv_prev && r_busy;
  assign w_last = r_wr_en && r_wr_idx == IDX_LAST;
  // Ack is applied before completion, so a same-cycle ack frees the read bank for the swap.
  assign w_held = r_frame_ready && !frame_ack;
`ifdef ADC_FRAME_BITREV_EN
  for (genvar b = 0; b < N_LOG2; b++) begin : g_rev
    assign w_waddr[b] = r_wr_idx[N_LOG2-1-b];
  end
`else
  assign w_waddr = r_wr_idx;
`endif
  assign sample      = w_fire;
  assign frame_ready = r_frame_ready;
  assign rd_data     = r_rd_data;
  assign overrun     = r_overrun;
  assign trig_miss   = r_trig_miss;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_div         <= '0;
      r_busy        <= 1'b0;
      r_dv_prev     <= 1'b0;
      r_wr_en       <= 1'b0;
      r_wr_idx      <= '0;
      r_wr_bank     <= 1'b0;
      r_rd_bank     <= 1'b1;
      r_frame_ready <= 1'b0;
      r_overrun     <= 1'b0;
      r_trig_miss   <= 1'b0;
      r_rd_data     <= '0;
    end else begin
      r_div         <= (!enable || w_tick) ? '0 : r_div + DW'(1);
      r_dv_prev     <= adc_dv;
      r_busy        <= w_fire || (r_busy && !w_cap);
      r_trig_miss   <= r_trig_miss || (w_tick && r_busy);
      r_wr_en       <= w_cap;
      r_wr_idx      <= r_wr_idx + N_LOG2'(r_wr_en);
      r_frame_ready <= w_held || w_last;
      r_overrun     <= r_overrun || (w_last && w_held);
      r_rd_bank     <= (w_last && !w_held) ? r_wr_bank : r_rd_bank;
      r_wr_bank     <= (w_last && !w_held) ? !r_wr_bank : r_wr_bank;
      r_rd_data     <= r_mem[{r_rd_bank, rd_addr}];
    end
  end
  always_ff @(posedge clk) begin
    if (w_cap) r_cap_data <= adc_data;
    if (r_wr_en) r_mem[{r_wr_bank, w_waddr}] <= r_cap_data;
  end
endmodule

// File: tb/tb_adc_frame_buffer.sv
// tb_adc_frame_buffer: scoreboard bench with a delayed-DV ADC model driving adc_frame_buffer.
module tb_adc_frame_buffer;
  logic       clk = 0, rst = 0, enable = 0, adc_dv = 0, frame_ack = 0;
  logic [7:0] adc_data = 0, rd_data;
  logic [2:0] rd_addr = 0;
  logic       sample, frame_ready, overrun, trig_miss;
  int n_chk = 0, n_fail = 0;
  int cyc = 0, dly = 10, cnt = 0, conv_cnt = 0, dv_rise_cyc = 0;
  bit pend = 0;
  logic [7:0] next_val = 8'h10;
  logic [7:0] exp_q[$];

  adc_frame_buffer #(.MSB(8), .N_LOG2(3), .SAMPLE_DIV(16)) dut (
    .clk(clk), .rst(rst), .enable(enable), .sample(sample), .adc_data(adc_data),
    .adc_dv(adc_dv), .frame_ready(frame_ready), .frame_ack(frame_ack),
    .rd_addr(rd_addr), .rd_data(rd_data), .overrun(overrun), .trig_miss(trig_miss));

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (sample) begin
      pend = 1;
      cnt = 0;
    end else if (pend) begin
      cnt++;
      if (cnt == dly) begin
        adc_dv = 1;
        adc_data = next_val;
        exp_q.push_back(next_val);
        next_val++;
        conv_cnt++;
        dv_rise_cyc = cyc;
      end else if (cnt == dly + 2) begin
        adc_dv = 0;
        pend = 0;
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  function automatic logic [2:0] br(input logic [2:0] a);
`ifdef ADC_FRAME_BITREV_EN
    return {a[0], a[1], a[2]};
`else
    return a;
`endif
  endfunction

  task automatic rd(input logic [2:0] a, output logic [7:0] d);
    @(negedge clk);
    rd_addr = a;
    @(posedge clk);
    #1;
    d = rd_data;
  endtask

  task automatic do_reset();
    enable = 0;
    frame_ack = 0;
    rd_addr = 0;
    for (int i = 0; i < 100 && (pend || adc_dv); i++) @(negedge clk);
    @(negedge clk);
    rst = 1;
    @(negedge clk);
    rst = 0;
    exp_q.delete();
    next_val = 8'h10;
    conv_cnt = 0;
    dly = 10;
  endtask

  task automatic test_reset();
    do_reset();
    n_chk++;
    if ({sample, frame_ready, overrun, trig_miss} !== 4'b0 || rd_data !== 8'h00) begin
      n_fail++;
      $display("FAIL reset: got s/fr/ov/tm=%b%b%b%b rd=%h expected 0000 rd=00",
               sample, frame_ready, overrun, trig_miss, rd_data);
    end
  endtask

  task automatic test_trigger();
    do_reset();
    enable = 1;
    for (int k = 1; k <= 48; k++) begin
      @(posedge clk);
      #1;
      n_chk++;
      if (sample !== (k % 16 == 15)) begin
        n_fail++;
        $display("FAIL trigger k=%0d: sample=%b expected %b", k, sample, k % 16 == 15);
      end
    end
    n_chk++;
    if (trig_miss !== 1'b0) begin
      n_fail++;
      $display("FAIL trigger trig_miss: got %b expected 0", trig_miss);
    end
  endtask

  logic [7:0] frame0 [8];

  task automatic test_frame();
    logic [7:0] d;
    bit ok = 0;
    do_reset();
    enable = 1;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk);
      #1;
      if (frame_ready) begin
        ok = 1;
        break;
      end
    end
    n_chk++;
    if (!ok || conv_cnt != 8 || cyc != dv_rise_cyc + 2) begin
      n_fail++;
      $display("FAIL frame_ready timing: ok=%0d conv=%0d cyc=%0d expected conv=8 cyc=%0d",
               ok, conv_cnt, cyc, dv_rise_cyc + 2);
    end
    n_chk++;
    if (overrun !== 1'b0) begin
      n_fail++;
      $display("FAIL frame overrun: got %b expected 0", overrun);
    end
    for (int i = 0; i < 8; i++) frame0[i] = exp_q.pop_front();
    for (int a = 0; a < 8; a++) begin
      rd(3'(a), d);
      n_chk++;
      if (d !== frame0[br(3'(a))]) begin
        n_fail++;
        $display("FAIL frame read addr=%0d: got %h expected %h", a, d, frame0[br(3'(a))]);
      end
    end
  endtask

  task automatic test_overrun();
    logic [7:0] d;
    for (int i = 0; i < 400 && conv_cnt < 24; i++) @(posedge clk);
    repeat (3) @(posedge clk);
    #1;
    n_chk++;
    if (conv_cnt < 24 || overrun !== 1'b1 || frame_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL overrun: conv=%0d ov=%b fr=%b expected conv=24 ov=1 fr=1",
               conv_cnt, overrun, frame_ready);
    end
    for (int a = 0; a < 8; a++) begin
      rd(3'(a), d);
      n_chk++;
      if (d !== frame0[br(3'(a))]) begin
        n_fail++;
        $display("FAIL overrun hold addr=%0d: got %h expected %h", a, d, frame0[br(3'(a))]);
      end
    end
  endtask

  task automatic test_ack_collide();
    logic [7:0] d;
    logic [7:0] fr [8];
    do_reset();
    enable = 1;
    for (int i = 0; i < 400 && !(conv_cnt == 16); i++) begin
      @(posedge clk);
      #1;
    end
    n_chk++;
    if (conv_cnt != 16 || frame_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL collide setup: conv=%0d fr=%b expected conv=16 fr=1", conv_cnt, frame_ready);
    end
    @(negedge clk);
    frame_ack = 1;
    @(posedge clk);
    #1;
    n_chk++;
    if (frame_ready !== 1'b1 || overrun !== 1'b0) begin
      n_fail++;
      $display("FAIL collide: fr=%b ov=%b expected fr=1 ov=0", frame_ready, overrun);
    end
    @(negedge clk);
    frame_ack = 0;
    for (int i = 0; i < 8; i++) void'(exp_q.pop_front());
    for (int i = 0; i < 8; i++) fr[i] = exp_q.pop_front();
    for (int a = 0; a < 8; a++) begin
      rd(3'(a), d);
      n_chk++;
      if (d !== fr[br(3'(a))]) begin
        n_fail++;
        $display("FAIL collide bank addr=%0d: got %h expected %h", a, d, fr[br(3'(a))]);
      end
    end
    @(negedge clk);
    frame_ack = 1;
    @(negedge clk);
    frame_ack = 0;
    n_chk++;
    if (frame_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL plain ack: fr=%b expected 0", frame_ready);
    end
    @(negedge clk);
    frame_ack = 1;
    @(negedge clk);
    frame_ack = 0;
    n_chk++;
    if (frame_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL idle ack: fr=%b expected 0", frame_ready);
    end
    for (int i = 0; i < 200 && !frame_ready; i++) begin
      @(posedge clk);
      #1;
    end
    n_chk++;
    if (frame_ready !== 1'b1 || overrun !== 1'b0 || conv_cnt != 24) begin
      n_fail++;
      $display("FAIL next frame: fr=%b ov=%b conv=%0d expected fr=1 ov=0 conv=24",
               frame_ready, overrun, conv_cnt);
    end
  endtask

  task automatic test_trig_miss();
    logic e;
    do_reset();
    dly = 20;
    enable = 1;
    for (int k = 1; k <= 96; k++) begin
      @(posedge clk);
      #1;
      e = (k == 15 || k == 47 || k == 79);
      n_chk++;
      if (sample !== e) begin
        n_fail++;
        $display("FAIL trig_miss sample k=%0d: got %b expected %b", k, sample, e);
      end
      n_chk++;
      if (trig_miss !== (k >= 32)) begin
        n_fail++;
        $display("FAIL trig_miss flag k=%0d: got %b expected %b", k, trig_miss, k >= 32);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0] d;
    logic [7:0] fr [8];
    do_reset();
    enable = 1;
    repeat (19) @(posedge clk);
    @(negedge clk);
    rst = 1;
    enable = 0;
    @(posedge clk);
    #1;
    n_chk++;
    if ({sample, frame_ready, overrun, trig_miss} !== 4'b0 || rd_data !== 8'h00) begin
      n_fail++;
      $display("FAIL mid reset: got s/fr/ov/tm=%b%b%b%b rd=%h expected 0000 rd=00",
               sample, frame_ready, overrun, trig_miss, rd_data);
    end
    @(negedge clk);
    rst = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      n_chk++;
      if (sample !== 1'b0 || frame_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL mid reset idle i=%0d: s=%b fr=%b expected 0 0", i, sample, frame_ready);
      end
    end
    @(negedge clk);
    exp_q.delete();
    conv_cnt = 0;
    next_val = 8'h40;
    enable = 1;
    for (int i = 0; i < 200 && !frame_ready; i++) begin
      @(posedge clk);
      #1;
    end
    n_chk++;
    if (frame_ready !== 1'b1 || conv_cnt != 8) begin
      n_fail++;
      $display("FAIL mid reset frame: fr=%b conv=%0d expected fr=1 conv=8", frame_ready, conv_cnt);
    end
    for (int i = 0; i < 8; i++) fr[i] = exp_q.pop_front();
    for (int a = 0; a < 8; a++) begin
      rd(3'(a), d);
      n_chk++;
      if (d !== fr[br(3'(a))]) begin
        n_fail++;
        $display("FAIL mid reset read addr=%0d: got %h expected %h", a, d, fr[br(3'(a))]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_trigger();
    test_frame();
    test_overrun();
    test_ack_collide();
    test_trig_miss();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
